// File: rtl/sr_latch_driver.sv
// Clocked command front-end for sr_latch: issues mutually exclusive S/R pulses,
// waits a settle window, then confirms the latch state via a 2-flop synchronizer.
module sr_latch_driver #(
  parameter int unsigned PULSE_W = 4,  // legal 1..255
  parameter int unsigned SETTLE  = 2   // legal 2..256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       S,
  output logic       R,
  input  logic       Q,
  output logic       q_sync,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_SET     = 2'b01,
    OP_RESET   = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_t;

  // Counters run from LOAD down to 0, so a phase lasts LOAD+1 cycles.
  localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_W - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  state_t     state;
  op_t        op_q;
  logic [7:0] cnt;
  logic       q_meta;
  logic       accept;
  logic       readback_bad;
  logic       err_set;

  // Q is asynchronous to clk; two flops before anything looks at it.
  // NOTE: non-blocking assignments in every clocked block, so each flop samples
  // the value its neighbour held before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_meta <= 1'b0;
      q_sync <= 1'b0;
    end else begin
      q_meta <= Q;
      q_sync <= q_meta;
    end
  end

  // Ready is masked by rst so nothing can be accepted while reset is held,
  // and comes back in the very first cycle rst is low.
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    readback_bad = 1'b0;
    err_set      = 1'b0;
    if (op_q == OP_SET && !q_sync) readback_bad = 1'b1;
    if (op_q == OP_RESET && q_sync) readback_bad = 1'b1;
    unique case (state)
      ST_IDLE:   err_set = accept && (op_t'(cmd_op) == OP_ILLEGAL);
      ST_SETTLE: err_set = (cnt == 8'd0) && readback_bad;
      default:   err_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      cnt       <= 8'd0;
      S         <= 1'b0;
      R         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      done <= 1'b0;
      err  <= err_set;
      if (err_set && err_count != 8'hFF) err_count <= err_count + 8'd1;

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= op_t'(cmd_op);
            unique case (op_t'(cmd_op))
              OP_SET: begin
                S     <= 1'b1;
                cnt   <= PULSE_LOAD;
                state <= ST_DRIVE;
              end
              OP_RESET: begin
                R     <= 1'b1;
                cnt   <= PULSE_LOAD;
                state <= ST_DRIVE;
              end
              default: begin
                done  <= 1'b1;
                state <= ST_CHECK;
              end
            endcase
          end
        end

        ST_DRIVE: begin
          if (cnt == 8'd0) begin
            S     <= 1'b0;
            R     <= 1'b0;
            cnt   <= SETTLE_LOAD;
            state <= ST_SETTLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_SETTLE: begin
          if (cnt == 8'd0) begin
            done  <= 1'b1;
            state <= ST_CHECK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_CHECK: begin
          state <= ST_IDLE;
        end

        default: begin
          S     <= 1'b0;
          R     <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: vector table, scoreboard on done,
// reset abort, PULSE_W=1 instance, held-valid streams and err_count saturation.
module tb_sr_latch_driver;

  localparam int PW0 = 4;
  localparam int LAT_DRV = 7;  // PULSE_W + SETTLE + 1 with defaults
  localparam int LAT_IMM = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ready, S, R, q_sync, busy, done, err;
  logic [7:0] err_count;
  logic       q_lat = 1'b0;
  logic       stuck = 1'b0;

  logic       v1 = 1'b0;
  logic [1:0] op1 = 2'b00;
  logic       ready1, s1, r1, qs1, busy1, done1, err1;
  logic [7:0] cnt1;
  logic       q1_lat = 1'b0;

  int errors = 0;
  int n_checks = 0;
  int cyc = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [1:0] op;
    logic       stuck;
    logic       exp_err;
    logic       exp_q;
    int         lat;
  } vec_t;

  typedef struct {
    int   t_acc;
    int   lat;
    logic exp_err;
    logic chk_q;
    logic exp_q;
  } sb_t;

  sb_t sb[$];

  sr_latch_driver dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .S(S), .R(R), .Q(q_lat), .q_sync(q_sync),
    .busy(busy), .done(done), .err(err), .err_count(err_count)
  );

  sr_latch_driver #(.PULSE_W(1), .SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_op(op1),
    .cmd_ready(ready1), .S(s1), .R(r1), .Q(q1_lat), .q_sync(qs1),
    .busy(busy1), .done(done1), .err(err1), .err_count(cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural latch models, updated away from the DUT clock edge.
  always @(negedge clk) begin
    if (stuck) q_lat <= 1'b0;
    else if (S) q_lat <= 1'b1;
    else if (R) q_lat <= 1'b0;
    if (s1) q1_lat <= 1'b1;
    else if (r1) q1_lat <= 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    assert (!(S && R) && !(s1 && r1))
    else begin
      errors++;
      $display("FAIL s_r_exclusive: S=%0b R=%0b s1=%0b r1=%0b", S, R, s1, r1);
    end
  end

  // Scoreboard: every done pops the oldest accepted command.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("latency", 32'(cyc - e.t_acc), 32'(e.lat));
          check("err", 32'(err), 32'(e.exp_err));
          if (e.chk_q) check("q_sync", 32'(q_sync), 32'(e.exp_q));
          if (e.exp_err && exp_cnt != 255) exp_cnt++;
          check("err_count", 32'(err_count), 32'(exp_cnt));
        end
      end
      if (err && !done) check("err_without_done", 32'(err), 32'd0);
    end
  end

  function automatic sb_t mk_entry(input logic [1:0] op, input logic exp_err, input logic exp_q);
    sb_t e;
    e.t_acc   = cyc;
    e.lat     = (op == 2'b01 || op == 2'b10) ? LAT_DRV : LAT_IMM;
    e.exp_err = exp_err;
    e.chk_q   = (op == 2'b01 || op == 2'b10);
    e.exp_q   = exp_q;
    return e;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait_bound", 32'(w < 50), 32'd1);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Issue one command and check the per-cycle waveform up to the cycle after done.
  task automatic issue(input vec_t v);
    logic drv;
    wait_ready();
    stuck     = v.stuck;
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    sb.push_back(mk_entry(v.op, v.exp_err, v.exp_q));
    drv = (v.op == 2'b01 || v.op == 2'b10);
    for (int k = 1; k <= v.lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0;
        cmd_op    = ~v.op;  // later op changes must be ignored
      end
      check("S_wave", 32'(S), 32'(v.op == 2'b01 && drv && k <= PW0));
      check("R_wave", 32'(R), 32'(v.op == 2'b10 && drv && k <= PW0));
      check("done_wave", 32'(done), 32'(k == v.lat));
      check("ready_wave", 32'(cmd_ready), 32'(k > v.lat));
      check("busy_wave", 32'(busy), 32'(k <= v.lat));
    end
  endtask

  initial begin
    vec_t vecs[7];
    int pushes;
    int w;

    vecs[0] = '{op: 2'b01, stuck: 1'b0, exp_err: 1'b0, exp_q: 1'b1, lat: LAT_DRV};
    vecs[1] = '{op: 2'b10, stuck: 1'b0, exp_err: 1'b0, exp_q: 1'b0, lat: LAT_DRV};
    vecs[2] = '{op: 2'b11, stuck: 1'b0, exp_err: 1'b1, exp_q: 1'b0, lat: LAT_IMM};
    vecs[3] = '{op: 2'b00, stuck: 1'b0, exp_err: 1'b0, exp_q: 1'b0, lat: LAT_IMM};
    vecs[4] = '{op: 2'b01, stuck: 1'b1, exp_err: 1'b1, exp_q: 1'b0, lat: LAT_DRV};
    vecs[5] = '{op: 2'b10, stuck: 1'b1, exp_err: 1'b0, exp_q: 1'b0, lat: LAT_DRV};
    vecs[6] = '{op: 2'b01, stuck: 1'b0, exp_err: 1'b0, exp_q: 1'b1, lat: LAT_DRV};

    // Reset with a command request pending: nothing may be accepted.
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    repeat (3) @(negedge clk);
    check("rst_S", 32'(S), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q_sync", 32'(q_sync), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) issue(vecs[i]);
    stuck = 1'b0;
    drain();

    // Reset pulsed during DRIVE aborts the command.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    @(negedge clk);  // T+1
    cmd_valid = 1'b0;
    check("abort_S_high", 32'(S), 32'd1);
    @(negedge clk);  // T+2
    rst = 1'b1;
    @(negedge clk);  // T+3
    check("abort_S_low", 32'(S), 32'd0);
    check("abort_R_low", 32'(R), 32'd0);
    check("abort_ready_in_rst", 32'(cmd_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err_count", 32'(err_count), 32'd0);
    exp_cnt = 0;
    rst = 1'b0;
    #1;
    check("abort_ready_after", 32'(cmd_ready), 32'd1);
    repeat (12) @(negedge clk);  // monitor flags any stray done
    check("abort_no_done", 32'(done), 32'd0);

    // PULSE_W=1, SETTLE=2 instance: done at T+4.
    check("pw1_ready", 32'(ready1), 32'd1);
    v1  = 1'b1;
    op1 = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) v1 = 1'b0;
      check("pw1_S", 32'(s1), 32'(k == 1));
      check("pw1_R", 32'(r1), 32'd0);
      check("pw1_done", 32'(done1), 32'(k == 4));
      check("pw1_ready", 32'(ready1), 32'(k == 5));
      if (k == 4) begin
        check("pw1_err", 32'(err1), 32'd0);
        check("pw1_q_sync", 32'(qs1), 32'd1);
      end
    end

    // cmd_valid held high with alternating ops: accepts happen only when ready.
    cmd_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      cmd_op = (i % 2 == 0) ? 2'b01 : 2'b10;
      if (cmd_ready) sb.push_back(mk_entry(cmd_op, 1'b0, cmd_op == 2'b01));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    drain();

    // 260 illegal ops: err_count saturates at 255.
    pushes = 0;
    w = 0;
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    while (pushes < 260 && w < 2000) begin
      if (cmd_ready) begin
        sb.push_back(mk_entry(2'b11, 1'b1, 1'b0));
        pushes++;
      end
      @(negedge clk);
      w++;
      if (pushes == 260) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    check("illegal_push_bound", 32'(pushes), 32'd260);
    drain();
    repeat (2) @(negedge clk);
    check("err_count_saturated", 32'(err_count), 32'd255);

    // No-op after saturation leaves the count alone.
    issue('{op: 2'b00, stuck: 1'b0, exp_err: 1'b0, exp_q: 1'b0, lat: LAT_IMM});
    drain();
    check("err_count_hold", 32'(err_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Clocked command front-end that drives the S/R inputs of the team's `sr_latch` and confirms the resulting state. It accepts set/reset commands over a valid/ready handshake and produces registered, mutually exclusive S/R pulses of a fixed width. After a settle window it reads back the latch Q through a 2-flop synchronizer and reports completion, plus an error on readback mismatch or an illegal command. It sits directly upstream of `sr_latch`: its S/R outputs feed the latch, and the latch Q returns to it.

## Interface
- `PULSE_W`, default 4: cycles S or R is held high per command; legal range 1..255.
- `SETTLE`, default 2: cycles S=R=0 between pulse end and readback; minimum 2, to cover the synchronizer.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_op` in 2: 2'b00 no-op, 2'b01 set, 2'b10 reset, 2'b11 illegal.
- `cmd_ready` out 1: command accepted on `cmd_valid & cmd_ready`.
- `S` out 1: latch set drive, registered.
- `R` out 1: latch reset drive, registered.
- `Q` in 1: latch output, asynchronous to `clk`.
- `q_sync` out 1: Q after 2 flops.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: single-cycle completion pulse.
- `err` out 1: single-cycle pulse, asserted only together with `done`.
- `err_count` out 8: saturating error count.

## Operation
- FSM states are IDLE, DRIVE, SETTLE and CHECK.
- IDLE
  - `cmd_ready` = 1.
  - On accept of set/reset, go to DRIVE with S=1 (set) or R=1 (reset) from the next cycle.
  - On accept of a no-op or illegal op, go straight to CHECK.
- DRIVE
  - Holds the selected S or R high for exactly `PULSE_W` cycles, using an internal 8-bit down-counter.
  - Then goes to SETTLE with S=R=0.
- SETTLE
  - S=R=0 for exactly `SETTLE` cycles, then goes to CHECK.
- CHECK
  - Lasts one cycle with `done`=1, then returns to IDLE.
  - `err`=1 if the op was set and `q_sync`≠1, or the op was reset and `q_sync`≠0.
  - `err`=1 unconditionally for op 2'b11.
  - A no-op never sets `err`.
- Invariant: S and R are never both 1 in any cycle, including across reset.
- `err_count` increments by 1 on every `err` pulse and saturates at 255 (no wrap).
- `cmd_op` is captured at accept; later changes on `cmd_op` or `cmd_valid` are ignored until `cmd_ready` returns.
- `cmd_valid` while not ready is not a command; nothing is queued.

## Timing
- Let T be the accept cycle.
- Set/reset:
  - S or R high in cycles T+1 .. T+PULSE_W.
  - Low from T+PULSE_W+1.
  - `done` in cycle T+PULSE_W+SETTLE+1.
  - With defaults, `done` is at T+7.
- No-op and illegal: `done` (and `err` for illegal) in cycle T+1.
- `cmd_ready` and `busy`:
  - `cmd_ready` is low from T+1 through the `done` cycle and high the cycle after `done`.
  - `busy` is the exact complement of `cmd_ready` outside reset.
  - Back-to-back throughput is therefore one command per PULSE_W+SETTLE+2 cycles.
- `q_sync` lags Q by 2 rising edges. CHECK samples the registered `q_sync` value.
- Reset values (cycle after `rst` is sampled high):
  - S=0, R=0, `done`=0, `err`=0, `busy`=0.
  - `q_sync`=0 and both sync flops cleared.
  - `err_count`=0, state IDLE.
  - `cmd_ready`=0 while `rst`=1, and 1 in the first cycle with `rst`=0.
- Reset mid-operation:
  - S/R drop on the next edge.
  - The command is aborted and no `done` or `err` is produced for it.
- `rst` has priority over accept in the same cycle.

## Test plan
- Reset, then set with defaults and a behavioural latch model: S=1 for exactly cycles T+1..T+4, R stays 0, `done`=1 and `err`=0 at T+7, `q_sync`=1, `cmd_ready` high at T+8.
- Reset after set: R=1 for 4 cycles, S=0 throughout, `done` at T+7 with `err`=0, `q_sync`=0.
- Illegal op 2'b11: S=R=0 throughout, `done`=`err`=1 at T+1, `err_count`=1, ready again at T+2. A subsequent no-op gives `done`=1, `err`=0 at T+1, with `err_count` still 1.
- Stuck fault (Q forced 0) and set command: `done`=1 and `err`=1 at T+7, `err_count` increments. Separately, PULSE_W=1, SETTLE=2 gives `done` at T+4.
- `rst` pulsed at T+2 during DRIVE: S=0 at T+3, no `done` ever for that command, `err_count`=0, `cmd_ready`=1 the first cycle after `rst` deasserts.
- `cmd_valid` held high with alternating ops: accepts only when ready, and an assertion that S&R is never 1 holds throughout. 260 illegal ops leave `err_count`=255.
